// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and counter types
// for the VGA timing generator (vga_timing_gen, vga_axis_counter).
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF
                         + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF
                         + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (wrapping counter + sync/active).
// Ports: clk_in, rst_n (sync, low), inc; count, wrap, sync_n, active.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF,
  parameter int VISIBLE    = H_VISIBLE_DEF,
  parameter bit RST_ACTIVE = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic inc,
  output cnt_t count,
  output logic wrap,
  output logic sync_n,
  output logic active
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);
  localparam cnt_t SS   = cnt_t'(SYNC_START);
  localparam cnt_t SE   = cnt_t'(SYNC_START + SYNC_LEN - 1);
  localparam cnt_t VIS  = cnt_t'(VISIBLE);

  cnt_t count_q, count_d;
  logic sync_n_q, sync_n_d;
  logic active_q, active_d;

  // sync/active are decoded from the next count so they
  // line up with count in the same cycle.
  always_comb begin
    wrap     = inc && (count_q == LAST);
    count_d  = count_q;
    sync_n_d = sync_n_q;
    active_d = active_q;
    if (inc) begin
      count_d  = wrap ? '0 : count_q + cnt_t'(1);
      sync_n_d = !((count_d >= SS) && (count_d <= SE));
      active_d = count_d < VIS;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      active_q <= RST_ACTIVE;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank/pixel-position timing generator.
// Ports: clk_in, rst_n (sync, low), pix_en; hsync, vsync, video_on,
//   blank_n, sync_n, pixel_x, pixel_y, frame_start, line_start.
// Option: define VGA_FRAME_CNT_EN to add 8-bit output frame_cnt.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             blank_n,
  output logic             sync_n,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic h_wrap, h_act;
  logic v_wrap, v_act;
  logic line_start_q, frame_start_q;

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .VISIBLE    (H_VISIBLE),
    .RST_ACTIVE (1'b0)
  ) u_h (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (pix_en),
    .count  (pixel_x),
    .wrap   (h_wrap),
    .sync_n (hsync),
    .active (h_act)
  );

  // Line 0 is visible, so the vertical axis leaves reset active;
  // the horizontal axis holds video_on low until the first advance.
  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .VISIBLE    (V_VISIBLE),
    .RST_ACTIVE (1'b1)
  ) u_v (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (h_wrap),
    .count  (pixel_y),
    .wrap   (v_wrap),
    .sync_n (vsync),
    .active (v_act)
  );

  // A wrap only happens on an advancing edge, so these pulses
  // are low on every pix_en=0 cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) frame_cnt_q <= 8'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign video_on    = h_act & v_act;
  assign blank_n     = video_on;
  assign sync_n      = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default 640x480 instance and a tiny
// instance against an arithmetic model of position vs advance count.
module tb_vga_timing_gen;

  localparam int SHV = 8, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic       b_hs, b_vs, b_vid, b_bn, b_sn, b_fs, b_ls;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_vid, s_bn, s_sn, s_fs, s_ls;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] b_fc, s_fc;
`endif

  vga_timing_gen u_big (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync       (b_hs),
    .vsync       (b_vs),
    .video_on    (b_vid),
    .blank_n     (b_bn),
    .sync_n      (b_sn),
    .pixel_x     (b_x),
    .pixel_y     (b_y),
    .frame_start (b_fs),
    .line_start  (b_ls)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (b_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (SHV), .H_FRONT (SHF),
    .H_SYNC    (SHS), .H_BACK  (SHB),
    .V_VISIBLE (SVV), .V_FRONT (SVF),
    .V_SYNC    (SVS), .V_BACK  (SVB)
  ) u_small (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vid),
    .blank_n     (s_bn),
    .sync_n      (s_sn),
    .pixel_x     (s_x),
    .pixel_y     (s_y),
    .frame_start (s_fs),
    .line_start  (s_ls)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (s_fc)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int b_tot = 0;
  int s_tot = 0;
  bit adv = 1'b0;
  bit ph = 1'b1;

  // Expected {x,y,hsync,vsync,video_on,blank_n,sync_n,fs,ls}
  // after `tot` advancing edges since reset.
  function automatic logic [26:0] model(
    int tot, bit a,
    int hv, int hf, int hs, int hb,
    int vv, int vf, int vs, int vb);
    int ht, vt, x, y;
    logic hsy, vsy, vid, fs, ls;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    x   = tot % ht;
    y   = (tot / ht) % vt;
    hsy = !(x >= hv + hf && x < hv + hf + hs);
    vsy = !(y >= vv + vf && y < vv + vf + vs);
    vid = (tot > 0) && x < hv && y < vv;
    ls  = a && x == 0;
    fs  = ls && y == 0;
    return {10'(x), 10'(y), hsy, vsy, vid, vid, 1'b0, fs, ls};
  endfunction

  task automatic check(string tag, logic [26:0] obs,
                       logic [26:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit p);
    rst_n  = r;
    pix_en = p;
    @(posedge clk);
    #1;
    if (!r) begin
      b_tot = 0;
      s_tot = 0;
    end else if (p) begin
      b_tot++;
      s_tot++;
    end
    adv = r && p;
    check("big",
      {b_x, b_y, b_hs, b_vs, b_vid, b_bn, b_sn, b_fs, b_ls},
      model(b_tot, adv, 640, 16, 96, 48, 480, 10, 2, 33));
    check("small",
      {s_x, s_y, s_hs, s_vs, s_vid, s_bn, s_sn, s_fs, s_ls},
      model(s_tot, adv, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
`ifdef VGA_FRAME_CNT_EN
    check("small_fcnt", 27'(s_fc), 27'((s_tot / SFR) % 256));
    check("big_fcnt", 27'(b_fc),
          27'((b_tot / (800 * 525)) % 256));
`endif
  endtask

  // Step until the small instance pulses frame_start (bounded).
  task automatic wait_fs(bit toggle, int limit,
                         output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      step(1'b1, toggle ? ph : 1'b1);
      ph = !ph;
      n++;
      if (s_fs) ok = 1'b1;
    end
  endtask

  logic vid_l[0:799];
  logic hs_l[0:799];
  int   n, hs_lo, vs_lo;
  bit   ok;

  initial begin
    // reset state, pix_en random
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom));
    check("rst_big", {b_x, b_y, b_hs, b_vs, b_vid, b_fs, b_ls},
          {20'd0, 5'b11000});
    check("rst_small", {s_x, s_y, s_hs, s_vs, s_vid, s_fs, s_ls},
          {20'd0, 5'b11000});

    // free run through the first full line of the big instance
    for (int i = 1; i <= 1000; i++) begin
      step(1'b1, 1'b1);
      if (i < 800) begin
        vid_l[i] = b_vid;
        hs_l[i]  = b_hs;
      end
      if (i == 800)
        check("line_wrap", {b_x, b_y, b_ls}, {10'd0, 10'd1, 1'b1});
    end
    check("vid_fall", {vid_l[639], vid_l[640]}, 27'b10);
    check("hs_fall", {hs_l[655], hs_l[656]}, 27'b10);
    check("hs_rise", {hs_l[751], hs_l[752]}, 27'b01);

    // one full small frame: sync duty and frame period
    wait_fs(1'b0, 2 * SFR, n, ok);
    check("wait_fs0", 27'(ok), 27'd1);
    hs_lo = 0;
    vs_lo = 0;
    for (int k = 1; k <= SFR; k++) begin
      step(1'b1, 1'b1);
      if (!s_hs) hs_lo++;
      if (!s_vs) vs_lo++;
      if (k < SFR && s_fs) check("early_fs", 27'(k), 27'(SFR));
    end
    check("hs_low_cnt", 27'(hs_lo), 27'(SHS * SVT));
    check("vs_low_cnt", 27'(vs_lo), 27'(SVS * SHT));
    check("wrap_coinc", {s_x, s_y, s_fs, s_ls, s_vs},
          {20'd0, 3'b111});

    // random pix_en
    for (int i = 0; i < 1500; i++) step(1'b1, 1'($urandom));

    // pix_en toggling 1,0,1,0: frame period doubles
    ph = 1'b1;
    wait_fs(1'b1, 4 * SFR, n, ok);
    check("wait_fs1", 27'(ok), 27'd1);
    wait_fs(1'b1, 4 * SFR, n, ok);
    check("wait_fs2", 27'(ok), 27'd1);
    check("tog_period", 27'(n), 27'(2 * SFR));

    // reset mid-frame with pix_en high
    for (int i = 0; i < 30 + int'($urandom_range(0, 40)); i++)
      step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("rst2_big", {b_x, b_y, b_hs, b_vs, b_vid, b_fs, b_ls},
          {20'd0, 5'b11000});
    check("rst2_small", {s_x, s_y, s_hs, s_vs, s_vid, s_fs, s_ls},
          {20'd0, 5'b11000});
    wait_fs(1'b0, 2 * SFR, n, ok);
    check("wait_fs3", 27'(ok), 27'd1);
    check("rst_period", 27'(n), 27'(SFR));

    // long free run: 257 small frames
    while (s_tot < 3 * SFR) step(1'b1, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    check("fcnt_3", 27'(s_fc), 27'd3);
`endif
    while (s_tot < 256 * SFR) step(1'b1, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    check("fcnt_wrap", 27'(s_fc), 27'd0);
`endif
    while (s_tot < 257 * SFR) step(1'b1, 1'b1);
    check("fs_257", {s_x, s_y, s_fs}, {20'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
